// File: rtl/stopwatch_key_ctrl.sv
// stopwatch_key_ctrl
//   Input-side front end of the stopwatch. It turns four raw push-buttons into
//   clean one-cycle commands. Each button passes through a 2-FF synchronizer,
//   a debouncer and a rising-edge detector. A 4-state FSM then drives the state
//   code, a clear pulse and a load pulse. The block also holds a BCD minutes
//   editor (00-59) that supplies the load value.
//
//   Optional feature macro: STOPWATCH_KEY_AUTOREP_EN
//     When defined, holding btn_inc in EDIT adds one increment every REP_CYCLES
//     cycles after the initial press. When undefined, each press gives exactly
//     one increment and no repeat counter is built.
//
// Parameters
//   DB_CYCLES  : stable cycles required before a level change is accepted
//   REP_CYCLES : auto-repeat period for btn_inc (used only with the macro)
//
// Ports
//   clk      in   system clock, all logic on posedge
//   reset    in   synchronous, active-high reset
//   btn_run  in   raw button: start/pause toggle
//   btn_clr  in   raw button: clear to 00:00 and go idle
//   btn_ld   in   raw button: enter edit / commit load
//   btn_inc  in   raw button: increment edit value
//   s        out  state code: 00 IDLE, 01 RUN, 10 PAUSE, 11 EDIT (also the FSM debug view)
//   clr_p    out  one-cycle clear pulse
//   load_p   out  one-cycle load pulse
//   load_val out  {tens[2:0], units[3:0]} BCD minutes, follows the edit value
//
// Handshake: there is no valid/ready pair. clr_p and load_p are single-cycle
// strobes that the counters sample on the next posedge. load_val is held
// stable for the whole cycle in which load_p is high.
module stopwatch_key_ctrl #(
  parameter int unsigned DB_CYCLES  = 1_000_000,
  parameter int unsigned REP_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_run,
  input  logic       btn_clr,
  input  logic       btn_ld,
  input  logic       btn_inc,
  output logic [1:0] s,
  output logic       clr_p,
  output logic       load_p,
  output logic [6:0] load_val
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  // Button lane indices
  localparam int B_RUN = 0;
  localparam int B_CLR = 1;
  localparam int B_LD  = 2;
  localparam int B_INC = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_EDIT  = 2'b11
  } state_t;

  logic [3:0]         raw;
  logic [3:0]         sync1_q, sync2_q;
  logic [3:0]         db_q, db_dly_q;
  logic [3:0][CW-1:0] cnt_q;
  logic [3:0]         press;

  assign raw   = {btn_inc, btn_ld, btn_clr, btn_run};
  assign press = db_q & ~db_dly_q;

  // Synchronize, debounce and edge-detect all four buttons.
  // The counter runs while the synchronized level disagrees with the accepted
  // level. Any agreement (a bounce) restarts it from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      db_dly_q <= db_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CW'(DB_CYCLES)) begin
          cnt_q[i] <= '0;
          db_q[i]  <= sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  state_t     state_q;
  logic [2:0] tens_q, tens_nx;
  logic [3:0] units_q, units_nx;
  logic       rep_fire;
  logic       inc_evt;

  // BCD +1 with wrap from 59 back to 00
  always_comb begin
    units_nx = units_q + 4'd1;
    tens_nx  = tens_q;
    if (units_q == 4'd9) begin
      units_nx = 4'd0;
      tens_nx  = (tens_q == 3'd5) ? 3'd0 : tens_q + 3'd1;
    end
  end

`ifdef STOPWATCH_KEY_AUTOREP_EN
  localparam int RW = $clog2(REP_CYCLES + 1);
  logic [RW-1:0] rep_cnt_q;

  // The repeat counter starts the cycle after the press pulse. It is held at
  // zero whenever the key is released or the FSM is outside EDIT.
  assign rep_fire = (state_q == ST_EDIT) && db_q[B_INC] && !press[B_INC] &&
                    (rep_cnt_q == RW'(REP_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || state_q != ST_EDIT || !db_q[B_INC] || press[B_INC]) begin
      rep_cnt_q <= '0;
    end else if (rep_cnt_q == RW'(REP_CYCLES - 1)) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_q + RW'(1);
    end
  end
`else
  // Repeat is disabled. REP_CYCLES only feeds this constant-false term.
  localparam bit RepPeriodSet = (REP_CYCLES != 0);
  assign rep_fire = 1'b0 & RepPeriodSet;
`endif

  assign inc_evt = press[B_INC] | rep_fire;

  // Command FSM. Priority on the same cycle is clr > ld > run > inc.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      clr_p   <= 1'b0;
      load_p  <= 1'b0;
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      clr_p  <= 1'b0;
      load_p <= 1'b0;
      if (press[B_CLR]) begin
        state_q <= ST_IDLE;
        clr_p   <= 1'b1;
        tens_q  <= '0;
        units_q <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE, ST_PAUSE: begin
            if (press[B_LD])       state_q <= ST_EDIT;
            else if (press[B_RUN]) state_q <= ST_RUN;
          end
          ST_RUN: begin
            if (press[B_RUN]) state_q <= ST_PAUSE;
          end
          ST_EDIT: begin
            if (press[B_LD]) begin
              state_q <= ST_PAUSE;
              load_p  <= 1'b1;
            end else if (inc_evt) begin
              tens_q  <= tens_nx;
              units_q <= units_nx;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign s        = state_q;
  assign load_val = {tens_q, units_q};

endmodule

// File: tb/tb_stopwatch_key_ctrl.sv
module tb_stopwatch_key_ctrl;

  localparam int DB  = 4;
  localparam int REP = 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       btn_run = 1'b0, btn_clr = 1'b0, btn_ld = 1'b0, btn_inc = 1'b0;
  logic [1:0] s;
  logic       clr_p, load_p;
  logic [6:0] load_val;

  stopwatch_key_ctrl #(.DB_CYCLES(DB), .REP_CYCLES(REP)) dut (
    .clk(clk), .reset(reset),
    .btn_run(btn_run), .btn_clr(btn_clr), .btn_ld(btn_ld), .btn_inc(btn_inc),
    .s(s), .clr_p(clr_p), .load_p(load_p), .load_val(load_val)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: one entry per output change {s, clr_p, load_p, load_val}
  logic [10:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic [10:0] prev_obs = '0;
  int          m_val = 0;  // model edit value 0..59

  function automatic logic [6:0] bcd(input int v);
    logic [2:0] t;
    logic [3:0] u;
    t = 3'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  task automatic push_evt(input logic [1:0] st, input logic c, input logic l, input logic [6:0] v);
    exp_q.push_back({st, c, l, v});
  endtask

  task automatic push_clr();
    m_val = 0;
    push_evt(2'b00, 1'b1, 1'b0, 7'h00);
    push_evt(2'b00, 1'b0, 1'b0, 7'h00);
  endtask

  always @(negedge clk) begin
    logic [10:0] cur;
    logic [10:0] e;
    cur = {s, clr_p, load_p, load_val};
    if (mon_en && !reset && cur != prev_obs) begin
      if (exp_q.size() == 0) begin
        check("unexpected_evt", 32'(cur), 32'(prev_obs));
      end else begin
        e = exp_q.pop_front();
        check("evt", 32'(cur), 32'(e));
      end
      check("pulse_excl", 32'(clr_p & load_p), 32'd0);
      check("bcd_range", 32'(load_val[3:0] <= 4'd9 && load_val[6:4] <= 3'd5), 32'd1);
    end
    prev_obs = cur;
  end

  // drivers
  task automatic set_btns(input logic [3:0] m);
    {btn_inc, btn_ld, btn_clr, btn_run} = m;
  endtask

  // mask bits: 0 run, 1 clr, 2 ld, 3 inc
  task automatic press(input logic [3:0] m);
    @(negedge clk);
    set_btns(m);
    repeat (DB + 6) @(negedge clk);
    set_btns(4'b0000);
    repeat (DB + 6 + $urandom_range(0, 3)) @(negedge clk);
  endtask

  initial begin
    logic [6:0] exp_auto;

    // 1. reset held 3 cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_s", 32'(s), 32'd0);
    check("rst_clr_p", 32'(clr_p), 32'd0);
    check("rst_load_p", 32'(load_p), 32'd0);
    check("rst_load_val", 32'(load_val), 32'd0);
    mon_en = 1'b1;

    // 2. bouncing run press, exact latency
    push_evt(2'b01, 1'b0, 1'b0, 7'h00);
    btn_run = 1'b1;
    @(negedge clk) btn_run = 1'b0;
    @(negedge clk) btn_run = 1'b1;   // final rise, next posedge is edge 0
    repeat (7) @(posedge clk);       // edges 0..6
    #1 check("lat_edge6_s", 32'(s), 32'd0);
    @(posedge clk);                  // edge 7
    #1 check("lat_edge7_s", 32'(s), 32'd1);
    repeat (4) @(negedge clk);
    btn_run = 1'b0;
    repeat (DB + 8) @(negedge clk);
    push_evt(2'b10, 1'b0, 1'b0, 7'h00);
    press(4'b0001);
    check("run_pause_s", 32'(s), 32'd2);

    // 3. clear to IDLE, edit, 61 increments, commit
    push_clr();
    press(4'b0010);
    push_evt(2'b11, 1'b0, 1'b0, 7'h00);
    press(4'b0100);
    for (int i = 0; i < 61; i++) begin
      m_val = (m_val + 1) % 60;
      push_evt(2'b11, 1'b0, 1'b0, bcd(m_val));
      press(4'b1000);
      if (i == 9)  check("step_09_10", 32'(load_val), 32'h10);
      if (i == 59) check("wrap_59_00", 32'(load_val), 32'h00);
    end
    check("edit_end_val", 32'(load_val), 32'h01);
    push_evt(2'b10, 1'b0, 1'b1, 7'h01);
    push_evt(2'b10, 1'b0, 1'b0, 7'h01);
    press(4'b0100);
    check("commit_s", 32'(s), 32'd2);

    // 4. RUN: ld/inc ignored, clr beats run and ld on the same cycle
    push_evt(2'b01, 1'b0, 1'b0, 7'h01);
    press(4'b0001);
    press(4'b0100);
    press(4'b1000);
    check("run_ignores_ld_inc", 32'(s), 32'd1);
    push_clr();
    press(4'b0011);
    push_evt(2'b01, 1'b0, 1'b0, 7'h00);
    press(4'b0001);
    push_clr();
    press(4'b0110);
    check("clr_ld_s", 32'(s), 32'd0);

    // 5. reset two cycles before debounce completes
    @(negedge clk);
    btn_run = 1'b1;
    repeat (4) @(posedge clk);       // edges 0..3
    @(negedge clk);
    reset = 1'b1;
    btn_run = 1'b0;
    repeat (2) @(negedge clk);       // reset sampled at edges 4 and 5
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_mid_db_s", 32'(s), 32'd0);
    push_evt(2'b01, 1'b0, 1'b0, 7'h00);
    press(4'b0001);
    check("new_press_run", 32'(s), 32'd1);

    // 6. auto-repeat hold in EDIT
    push_clr();
    press(4'b0010);
    push_evt(2'b11, 1'b0, 1'b0, 7'h00);
    press(4'b0100);
    push_evt(2'b11, 1'b0, 1'b0, 7'h01);
`ifdef STOPWATCH_KEY_AUTOREP_EN
    push_evt(2'b11, 1'b0, 1'b0, 7'h02);
    push_evt(2'b11, 1'b0, 1'b0, 7'h03);
    exp_auto = 7'h03;
`else
    exp_auto = 7'h01;
`endif
    @(negedge clk);
    btn_inc = 1'b1;
    repeat (20) @(negedge clk);
    btn_inc = 1'b0;
    repeat (DB + 12) @(negedge clk);
    check("autorep_val", 32'(load_val), 32'(exp_auto));

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
